sobel_edge_engine: RTL and testbench

SOBEL_EDGE_ENGINE -- requirements
Module: sobel_edge_engine

---
 rtl/sobel_edge_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_sobel_edge_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_engine.sv
// Streaming 3x3 Sobel edge engine with two line buffers, a 3-stage pipeline,
// per-frame captured mode/threshold and border masking.
module sobel_edge_engine #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int SHIFT  = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  input  logic              iTHR_EN,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oEOL
);

  localparam int CW = $clog2(IMG_W);
  localparam int GW = DATA_W + 3;
  localparam int MW = DATA_W + 4;
  localparam logic [CW-1:0]     LAST_COL = CW'(IMG_W - 1);
  localparam logic [DATA_W-1:0] PIX_MAX  = '1;

  typedef logic [DATA_W-1:0] pix_t;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [1:0]    row_q, row_d, cur_row;
  logic [1:0]    cfg_mode_q, cfg_mode_d;
  logic          cfg_thr_en_q, cfg_thr_en_d;
  pix_t          cfg_thresh_q, cfg_thresh_d;

  logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
  logic       s1_vld_q, s1_vld_d, s1_mask_q, s1_mask_d, s1_eol_q, s1_eol_d;
  logic [1:0] s1_mode_q, s1_mode_d;
  logic       s1_thr_en_q, s1_thr_en_d;
  pix_t       s1_thresh_q, s1_thresh_d;

  logic       s2_vld_q, s2_vld_d, s2_mask_q, s2_mask_d, s2_eol_q, s2_eol_d;
  logic [1:0] s2_mode_q, s2_mode_d;
  logic       s2_thr_en_q, s2_thr_en_d;
  pix_t       s2_thresh_q, s2_thresh_d, s2_mag_q, s2_mag_d, s2_center_q, s2_center_d;

  pix_t o_data_q, o_data_d;
  logic o_dval_q, o_dval_d, o_eol_q, o_eol_d;

  pix_t lb_prev_mem [IMG_W];
  pix_t lb_old_mem  [IMG_W];
  pix_t prev_rd, old_rd;

  logic [GW-1:0]        sum_l, sum_r, sum_t, sum_b, ax, ay;
  logic signed [GW-1:0] gx, gy;
  logic [MW-1:0]        mag, mag_sh;
  pix_t                 mag_sat;

  // A frame start overrides whatever position the counters hold.
  assign cur_col = iSOF ? '0 : col_q;
  assign cur_row = iSOF ? 2'd0 : row_q;
  assign prev_rd = lb_prev_mem[cur_col];
  assign old_rd  = lb_old_mem[cur_col];

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb_prev_mem[cur_col] <= iDATA;
      lb_old_mem[cur_col]  <= prev_rd;
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    cfg_mode_d   = cfg_mode_q;
    cfg_thr_en_d = cfg_thr_en_q;
    cfg_thresh_d = cfg_thresh_q;
    win_d        = win_q;
    s1_vld_d     = iDVAL;
    s1_mask_d    = s1_mask_q;
    s1_eol_d     = s1_eol_q;
    s1_mode_d    = s1_mode_q;
    s1_thr_en_d  = s1_thr_en_q;
    s1_thresh_d  = s1_thresh_q;
    if (iDVAL) begin
      if (iSOF) begin
        cfg_mode_d   = iMODE;
        cfg_thr_en_d = iTHR_EN;
        cfg_thresh_d = iTHRESH;
      end
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = old_rd;
      win_d[1][2] = prev_rd;
      win_d[2][2] = iDATA;
      s1_mask_d   = (cur_row < 2'd2) || (cur_col < CW'(2));
      s1_eol_d    = (cur_col == LAST_COL);
      s1_mode_d   = cfg_mode_d;
      s1_thr_en_d = cfg_thr_en_d;
      s1_thresh_d = cfg_thresh_d;
    end
  end

  function automatic logic [GW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  always_comb begin
    sum_l = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    sum_r = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
    sum_t = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
    sum_b = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
    gx    = $signed(sum_r) - $signed(sum_l);
    gy    = $signed(sum_b) - $signed(sum_t);
    ax    = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay    = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    case (s1_mode_q)
      2'b00:   mag = {1'b0, ax};
      2'b01:   mag = {1'b0, ay};
      default: mag = {1'b0, ax} + {1'b0, ay};
    endcase
    mag_sh  = mag >> SHIFT;
    mag_sat = (mag_sh > MW'(PIX_MAX)) ? PIX_MAX : mag_sh[DATA_W-1:0];

    s2_vld_d    = s1_vld_q;
    s2_mask_d   = s2_mask_q;
    s2_eol_d    = s2_eol_q;
    s2_mode_d   = s2_mode_q;
    s2_thr_en_d = s2_thr_en_q;
    s2_thresh_d = s2_thresh_q;
    s2_mag_d    = s2_mag_q;
    s2_center_d = s2_center_q;
    if (s1_vld_q) begin
      s2_mask_d   = s1_mask_q;
      s2_eol_d    = s1_eol_q;
      s2_mode_d   = s1_mode_q;
      s2_thr_en_d = s1_thr_en_q;
      s2_thresh_d = s1_thresh_q;
      s2_mag_d    = mag_sat;
      s2_center_d = win_q[1][1];
    end
  end

  // Passthrough bypasses masking and thresholding entirely.
  always_comb begin
    o_dval_d = s2_vld_q;
    o_eol_d  = s2_vld_q & s2_eol_q;
    o_data_d = o_data_q;
    if (s2_vld_q) begin
      if (s2_mode_q == 2'b11)  o_data_d = s2_center_q;
      else if (s2_mask_q)      o_data_d = '0;
      else if (s2_thr_en_q)    o_data_d = (s2_mag_q >= s2_thresh_q) ? PIX_MAX : '0;
      else                     o_data_d = s2_mag_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q        <= '0;
      row_q        <= '0;
      cfg_mode_q   <= 2'b10;
      cfg_thr_en_q <= 1'b0;
      cfg_thresh_q <= '0;
      win_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_mask_q    <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_mode_q    <= 2'b10;
      s1_thr_en_q  <= 1'b0;
      s1_thresh_q  <= '0;
      s2_vld_q     <= 1'b0;
      s2_mask_q    <= 1'b0;
      s2_eol_q     <= 1'b0;
      s2_mode_q    <= 2'b10;
      s2_thr_en_q  <= 1'b0;
      s2_thresh_q  <= '0;
      s2_mag_q     <= '0;
      s2_center_q  <= '0;
      o_data_q     <= '0;
      o_dval_q     <= 1'b0;
      o_eol_q      <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cfg_mode_q   <= cfg_mode_d;
      cfg_thr_en_q <= cfg_thr_en_d;
      cfg_thresh_q <= cfg_thresh_d;
      win_q        <= win_d;
      s1_vld_q     <= s1_vld_d;
      s1_mask_q    <= s1_mask_d;
      s1_eol_q     <= s1_eol_d;
      s1_mode_q    <= s1_mode_d;
      s1_thr_en_q  <= s1_thr_en_d;
      s1_thresh_q  <= s1_thresh_d;
      s2_vld_q     <= s2_vld_d;
      s2_mask_q    <= s2_mask_d;
      s2_eol_q     <= s2_eol_d;
      s2_mode_q    <= s2_mode_d;
      s2_thr_en_q  <= s2_thr_en_d;
      s2_thresh_q  <= s2_thresh_d;
      s2_mag_q     <= s2_mag_d;
      s2_center_q  <= s2_center_d;
      o_data_q     <= o_data_d;
      o_dval_q     <= o_dval_d;
      o_eol_q      <= o_eol_d;
    end
  end

  assign oDATA = o_data_q;
  assign oDVAL = o_dval_q;
  assign oEOL  = o_eol_q;

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Randomized bench for sobel_edge_engine: an image-level Sobel model and a
// pixel-history model of the window centre predict every output.
module tb_sobel_edge_engine;
  localparam int W    = 8;
  localparam int MAXV = 4095;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [11:0] iDATA = '0, iTHRESH = '0;
  logic        iDVAL = 1'b0, iSOF = 1'b0, iTHR_EN = 1'b0;
  logic [1:0]  iMODE = 2'b00;
  logic [11:0] oDATA, oDATA_s1;
  logic        oDVAL, oEOL, oDVAL_s1, oEOL_s1;

  always #5 iCLK = ~iCLK;

  sobel_edge_engine #(.DATA_W(12), .IMG_W(W), .SHIFT(0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iMODE(iMODE), .iTHR_EN(iTHR_EN), .iTHRESH(iTHRESH),
    .oDATA(oDATA), .oDVAL(oDVAL), .oEOL(oEOL));

  sobel_edge_engine #(.DATA_W(12), .IMG_W(W), .SHIFT(1)) dut_s1 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iMODE(iMODE), .iTHR_EN(iTHR_EN), .iTHRESH(iTHRESH),
    .oDATA(oDATA_s1), .oDVAL(oDVAL_s1), .oEOL(oEOL_s1));

  int n_cmp = 0, n_fail = 0, cyc = 0, stray_eol = 0;
  int frm [8][8];
  int exp_d[$], exp_s[$], exp_c[$], got_d[$], got_s[$], got_c[$], hist[$];
  bit exp_e[$], got_e[$];

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (oDVAL) begin
      got_d.push_back(int'(oDATA));
      got_e.push_back(oEOL);
      got_c.push_back(cyc);
    end
    if (oDVAL_s1) got_s.push_back(int'(oDATA_s1));
    if (oEOL && !oDVAL) stray_eol++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sobel magnitude of image pixel (r,c) straight from the frame array.
  function automatic int model(int r, int c, int mode, bit te, int th, int sh);
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    gx = (frm[r-2][c] + 2*frm[r-1][c] + frm[r][c]) - (frm[r-2][c-2] + 2*frm[r-1][c-2] + frm[r][c-2]);
    gy = (frm[r][c-2] + 2*frm[r][c-1] + frm[r][c]) - (frm[r-2][c-2] + 2*frm[r-2][c-1] + frm[r-2][c]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (mode == 0) ? gx : (mode == 1) ? gy : gx + gy;
    m = m >> sh;
    if (m > MAXV) m = MAXV;
    if (te) m = (m >= th) ? MAXV : 0;
    return m;
  endfunction

  task automatic clear_q();
    exp_d.delete(); exp_s.delete(); exp_c.delete(); exp_e.delete();
    got_d.delete(); got_s.delete(); got_c.delete(); got_e.delete();
    stray_eol = 0;
  endtask

  task automatic drive(input int d, input bit dv, input bit sof, input int m, input bit te, input int th);
    @(posedge iCLK);
    #1;
    iDATA = 12'(d); iDVAL = dv; iSOF = sof; iMODE = 2'(m); iTHR_EN = te; iTHRESH = 12'(th);
    if (dv) begin
      hist.push_back(d);
      exp_c.push_back(cyc + 3);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(int'($urandom_range(MAXV)), 1'b0, 1'($urandom_range(1)),
                     int'($urandom_range(3)), 1'($urandom_range(1)), int'($urandom_range(MAXV)));
  endtask

  // Streams frm; the frame config applies only if sof, otherwise the reset config.
  task automatic run_frame(input int mode, input bit te, input int th, input int gap,
                           input bit scramble, input bit sof);
    int em, eth, n, v;
    bit ete, first;
    em = sof ? mode : 2; ete = sof ? te : 1'b0; eth = sof ? th : 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < gap) idle(1);
        first = (r == 0 && c == 0);
        if ((first && sof) || !scramble) drive(frm[r][c], 1'b1, first && sof, mode, te, th);
        else drive(frm[r][c], 1'b1, 1'b0, int'($urandom_range(3)), 1'($urandom_range(1)),
                   int'($urandom_range(MAXV)));
        if (em == 3) begin
          n = hist.size() - 1;
          v = (n >= W + 1) ? hist[n-W-1] : -1;
          exp_d.push_back(v); exp_s.push_back(v);
        end else begin
          exp_d.push_back(model(r, c, em, ete, eth, 0));
          exp_s.push_back(model(r, c, em, ete, eth, 1));
        end
        exp_e.push_back(c == W - 1);
      end
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    #23;
    @(negedge iCLK) iRST = 1'b0;
    for (int i = 0; i < 14; i++) drive(int'($urandom_range(1, MAXV)), 1'b1, i == 0, 3, 1'b0, 0);
    @(posedge iCLK);
    #3;
    iDVAL = 1'b0;
    iRST  = 1'b1;
    #1;
    n_cmp++; if (oDVAL !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dval got %0b want 0", oDVAL); end
    n_cmp++; if (oEOL !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_eol got %0b want 0", oEOL); end
    n_cmp++; if (oDATA !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_data got %0d want 0", oDATA); end
    repeat (2) begin
      @(negedge iCLK);
      n_cmp++; if (oDVAL !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hold_dval got %0b want 0", oDVAL); end
    end
    clear_q();
    hist.delete();
    @(negedge iCLK) iRST = 1'b0;
  endtask

  task automatic test_reset_config();
    clear_q();
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = int'($urandom_range(1023));
    run_frame(0, 1'b1, 100, 0, 1'b1, 1'b0);
    idle(6);
    n_cmp++; if (got_d.size() !== exp_d.size()) begin n_fail++; $display("[TB] FAIL rstcfg_count got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL rstcfg_data[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_flat();
    int eols;
    clear_q();
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = 100;
    run_frame(2, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(6);
    eols = 0;
    foreach (got_e[i]) if (got_e[i]) eols++;
    n_cmp++; if (got_d.size() !== 64) begin n_fail++; $display("[TB] FAIL flat_dval_count got %0d want 64", got_d.size()); end
    n_cmp++; if (eols !== 8) begin n_fail++; $display("[TB] FAIL flat_eol_count got %0d want 8", eols); end
    n_cmp++; if (stray_eol !== 0) begin n_fail++; $display("[TB] FAIL flat_eol_without_dval got %0d want 0", stray_eol); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== 0) begin n_fail++; $display("[TB] FAIL flat_data[%0d] got %0d want 0", i, got_d[i]); end
      n_cmp++; if (got_c[i] !== exp_c[i]) begin n_fail++; $display("[TB] FAIL flat_latency[%0d] got cycle %0d want %0d", i, got_c[i], exp_c[i]); end
      n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("[TB] FAIL flat_eol[%0d] got %0b want %0b", i, got_e[i], exp_e[i]); end
    end
  endtask

  task automatic test_step_image();
    int modes[5] = '{0, 1, 2, 0, 0};
    bit tens[5]  = '{0, 0, 0, 1, 1};
    int ths[5]   = '{0, 0, 0, 4000, 4001};
    int lit0[5]  = '{4000, 0, 4000, 4095, 0};
    int lit1[5]  = '{2000, 0, 2000, 0, 0};
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = (c >= 4) ? 1000 : 0;
    for (int k = 0; k < 5; k++) begin
      clear_q();
      run_frame(modes[k], tens[k], ths[k], 0, 1'b0, 1'b1);
      idle(6);
      n_cmp++; if (got_d.size() !== 64 || got_s.size() !== 64) begin n_fail++; $display("[TB] FAIL step%0d_count got %0d/%0d want 64", k, got_d.size(), got_s.size()); end
      if (got_d.size() > 38 && got_s.size() > 38) begin
        n_cmp++; if (got_d[36] !== lit0[k]) begin n_fail++; $display("[TB] FAIL step%0d_col4 got %0d want %0d", k, got_d[36], lit0[k]); end
        n_cmp++; if (got_d[37] !== lit0[k]) begin n_fail++; $display("[TB] FAIL step%0d_col5 got %0d want %0d", k, got_d[37], lit0[k]); end
        n_cmp++; if (got_d[38] !== 0) begin n_fail++; $display("[TB] FAIL step%0d_col6 got %0d want 0", k, got_d[38]); end
        n_cmp++; if (got_s[36] !== lit1[k]) begin n_fail++; $display("[TB] FAIL step%0d_shift_col4 got %0d want %0d", k, got_s[36], lit1[k]); end
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size() && i < got_s.size(); i++) begin
        n_cmp++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL step%0d_data[%0d] got %0d want %0d", k, i, got_d[i], exp_d[i]); end
        n_cmp++; if (got_s[i] !== exp_s[i]) begin n_fail++; $display("[TB] FAIL step%0d_shift_data[%0d] got %0d want %0d", k, i, got_s[i], exp_s[i]); end
        n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("[TB] FAIL step%0d_eol[%0d] got %0b want %0b", k, i, got_e[i], exp_e[i]); end
      end
    end
  endtask

  task automatic test_gaps_and_config(input int gap, input int range, input string tag);
    for (int f = 0; f < 2; f++) begin
      clear_q();
      for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = int'($urandom_range(range));
      run_frame(int'($urandom_range(2)), 1'($urandom_range(1)), int'($urandom_range(MAXV)), gap, 1'b1, 1'b1);
      idle(6);
      n_cmp++; if (got_d.size() !== exp_d.size()) begin n_fail++; $display("[TB] FAIL %s_count got %0d want %0d", tag, got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size() && i < got_s.size(); i++) begin
        n_cmp++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL %s_data[%0d] got %0d want %0d", tag, i, got_d[i], exp_d[i]); end
        n_cmp++; if (got_s[i] !== exp_s[i]) begin n_fail++; $display("[TB] FAIL %s_shift_data[%0d] got %0d want %0d", tag, i, got_s[i], exp_s[i]); end
        n_cmp++; if (got_c[i] !== exp_c[i]) begin n_fail++; $display("[TB] FAIL %s_latency[%0d] got cycle %0d want %0d", tag, i, got_c[i], exp_c[i]); end
      end
    end
  endtask

  task automatic test_passthrough();
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = c * 10;
    for (int f = 0; f < 2; f++) begin
      clear_q();
      run_frame(3, 1'b1, MAXV, 30, 1'b1, 1'b1);
      idle(6);
      n_cmp++; if (got_d.size() !== 64) begin n_fail++; $display("[TB] FAIL pass_count got %0d want 64", got_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size() && i < got_s.size(); i++) begin
        if (exp_d[i] >= 0) begin
          n_cmp++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL pass_data[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
          n_cmp++; if (got_s[i] !== exp_s[i]) begin n_fail++; $display("[TB] FAIL pass_shift_data[%0d] got %0d want %0d", i, got_s[i], exp_s[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) frm[r][c] = (c >= 4) ? 1000 : 0;
    for (int i = 0; i < 20; i++) drive(frm[i/W][i%W], 1'b1, i == 0, 0, 1'b0, 0);
    @(posedge iCLK);
    #2;
    iDVAL = 1'b0;
    iRST  = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      n_cmp++; if (oDVAL !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_dval got %0b want 0", oDVAL); end
    end
    clear_q();
    hist.delete();
    @(negedge iCLK) iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(MAXV)), 1'b1, 1'b0, 0, 1'b0, 0);
      exp_d.push_back(0); exp_s.push_back(0); exp_e.push_back(1'b0);
    end
    run_frame(0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(6);
    n_cmp++; if (got_d.size() !== 67) begin n_fail++; $display("[TB] FAIL midrst_count got %0d want 67", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL midrst_data[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
      n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("[TB] FAIL midrst_eol[%0d] got %0b want %0b", i, got_e[i], exp_e[i]); end
      n_cmp++; if (got_c[i] !== exp_c[i]) begin n_fail++; $display("[TB] FAIL midrst_latency[%0d] got cycle %0d want %0d", i, got_c[i], exp_c[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_config();
    test_flat();
    test_step_image();
    test_gaps_and_config(50, MAXV, "gaps");
    test_gaps_and_config(0, 800, "back_to_back");
    test_passthrough();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
